pc_trace_stream: RTL and testbench
==================================

Name: pc_trace_stream

Overview:
Parametrised PC-trace streamer for the online debug path. It captures retired-PC samples from the core into an internal FIFO. Each PC is serialised into TDATA_WIDTH-wide AXI-Stream beats, with packet framing via tlast, overflow accounting and a terminal error record. It sits between the core's PC/valid/error outputs and the debug DMA/UART bridge.

Parameters:
PC_WIDTH, 32, width of one PC sample; must be an integer multiple of TDATA_WIDTH.
TDATA_WIDTH, 16, AXI-Stream data width; BEATS = PC_WIDTH/TDATA_WIDTH.
FIFO_DEPTH, 32, PC entries buffered; power of two, >= 2.
PKT_LEN, 16, PC records per packet; tlast on the last beat of every PKT_LEN-th record; >= 1.
ERR_WORD, 32'h0000_0001, PC_WIDTH-wide payload of the error record.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_pc  in  PC_WIDTH  PC sample
i_pc_valid  in  1  sample strobe, one entry per cycle
i_error  in  1  core error/trap indication, level or pulse
i_flush  in  1  single-cycle request to close the current packet early
i_clear  in  1  single-cycle release of halted state and counters
M_AXIS_tvalid  out  1
M_AXIS_tready  in  1
M_AXIS_tdata  out  TDATA_WIDTH
M_AXIS_tlast  out  1
o_overflow  out  1  sticky: at least one sample dropped
o_drop_count  out  16  dropped samples, saturates at 16'hFFFF
o_halted  out  1  error record sent; stream stopped

Behaviour:
- Reset: the clock is clk. Reset is asynchronous and active-high on port rst. All outputs are 0 during reset; the FIFO is empty; the FSM is in IDLE; the beat and packet counters are 0.
- Write side: i_pc_valid with FIFO not full writes i_pc. If i_pc_valid arrives with the FIFO full, the sample is dropped, o_overflow is set, and o_drop_count increments (saturating). Once the error is latched or the block is halted, i_pc_valid is ignored and not counted.
- Error capture: i_error sets the sticky err_pend flag. If i_pc_valid and i_error coincide, that PC is written first; the error record follows it.
- FSM states: IDLE, BEAT, ERR_BEAT, HALT.
  - IDLE -> BEAT when the FIFO is non-empty. The FIFO head is popped into a PC_WIDTH shift register, beat_cnt is cleared, and tvalid is asserted.
  - IDLE -> ERR_BEAT when the FIFO is empty and err_pend is set. The shift register is loaded with ERR_WORD.
- Beat ordering: least-significant TDATA_WIDTH slice first. On each tvalid&&tready the register shifts right by TDATA_WIDTH and beat_cnt increments.
- AXI rules: tdata and tlast are held stable while tvalid && !tready; tvalid never drops without a handshake.
- Back-to-back throughput: on the last-beat handshake, if the FIFO is non-empty and no error is pending, the next record is loaded in the same cycle. This gives 1 beat/cycle sustained with no bubble.
- Latency: i_pc_valid in cycle N gives first-beat tvalid at N+2 when the FIFO was empty and the FSM was idle.
- tlast in BEAT: asserted only on beat BEATS-1, and only when either pkt_cnt == PKT_LEN-1 or flush_pend is set. On that handshake pkt_cnt and flush_pend clear; otherwise pkt_cnt increments on each record's last beat.
- Flush: i_flush sets flush_pend only while a record is in flight or the FIFO is non-empty; otherwise it is ignored.
- Error record: ERR_BEAT emits BEATS beats of ERR_WORD with tlast on the final beat, regardless of pkt_cnt. After the final handshake the FSM goes to HALT, o_halted = 1 and tvalid = 0.
- Pending error ordering: records already in the FIFO when the error is latched drain first, then the error record follows.
- HALT: the block stays halted until i_clear. i_clear clears o_halted, err_pend, o_overflow, o_drop_count and pkt_cnt, and returns the FSM to IDLE. In states other than HALT, i_clear clears only o_overflow and o_drop_count.
- Reset mid-beat: tvalid drops immediately (asynchronous); the partial record is lost and no recovery is attempted.

Decomposition:
- Shared package pc_trace_pkg: the FSM state enum; the BEATS and clog2-derived counter widths; the default ERR_WORD constant.
- Sub-module pc_trace_fifo: show-ahead synchronous FIFO, parametrised by width and depth. It has full and empty flags, async active-high reset, and defined behaviour on simultaneous read and write when full (both succeed).

Test Plan:
- Single sample: one i_pc_valid with PC 0x8000_0004 and tready = 1 -> beats 0x0004 then 0x8000; tvalid first asserts 2 cycles after valid; tlast = 0.
- Packet framing: 16 consecutive PCs 0x100, 0x104, ... with tready = 1 -> 32 beats with no bubbles; tlast only on beat 32 (tdata 0x0000, high half of 0x13C).
- Backpressure: tready held low for 10 cycles mid-record -> tdata and tlast stable, tvalid high throughout; no beat lost or duplicated.
- Overflow: tready = 0 while 40 samples are written -> 32 stored; o_overflow = 1 and o_drop_count = 8; the stream then drains exactly 32 records in order.
- Error ordering: 3 PCs written, then i_error in the same cycle as a 4th PC -> 4 records, then beats 0x0001 and 0x0000 (tlast = 1); o_halted = 1; later i_pc_valid is ignored; i_clear resumes normal capture.
- Flush and reset: i_flush during record 5 -> tlast on that record's last beat and pkt_cnt restarts. Asserting rst mid-beat -> tvalid = 0 that cycle and all counters read 0.

Source files
------------

// File: rtl/pc_trace_pkg.sv
// Shared types and derived sizes for the PC-trace streamer.
// Module-level parameters override the defaults; cnt_width() sizes their counters.
package pc_trace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        ERR_BEAT,
        HALT
    } state_t;

    localparam int          DEF_PC_WIDTH    = 32;
    localparam int          DEF_TDATA_WIDTH = 16;
    localparam int          DEF_FIFO_DEPTH  = 32;
    localparam int          DEF_PKT_LEN     = 16;
    localparam logic [31:0] DEF_ERR_WORD    = 32'h0000_0001;

    // A counter for n values needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_BEATS  = DEF_PC_WIDTH / DEF_TDATA_WIDTH;
    localparam int DEF_BEAT_W = cnt_width(DEF_BEATS);
    localparam int DEF_PKT_W  = cnt_width(DEF_PKT_LEN);

endpackage

// File: rtl/pc_trace_stream_if.sv
// AXI-Stream channel carrying serialised PC beats towards the debug bridge.
interface pc_trace_stream_if #(
    parameter int TDATA_WIDTH = 16
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/pc_trace_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the head entry.
// A write while full succeeds when a read happens in the same cycle.
module pc_trace_fifo
    import pc_trace_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pc_trace_stream.sv
// Captures retired PCs into a FIFO and serialises them LSB-slice first onto
// AXI-Stream, with packet framing, drop accounting and a terminal error record.
module pc_trace_stream
    import pc_trace_pkg::*;
#(
    parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
    parameter int                  TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int                  FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int                  PKT_LEN     = DEF_PKT_LEN,
    parameter logic [PC_WIDTH-1:0] ERR_WORD    = PC_WIDTH'(DEF_ERR_WORD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic                i_pc_valid,
    input  logic                i_error,
    input  logic                i_flush,
    input  logic                i_clear,
    pc_trace_stream_if.master   M_AXIS,
    output logic                o_overflow,
    output logic [15:0]         o_drop_count,
    output logic                o_halted
);
    localparam int BEATS  = PC_WIDTH / TDATA_WIDTH;
    localparam int BEAT_W = cnt_width(BEATS);
    localparam int PKT_W  = cnt_width(PKT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [PKT_W-1:0]  LAST_REC  = PKT_W'(PKT_LEN - 1);

    state_t              state;
    logic [PC_WIDTH-1:0] shreg;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   next_beat;
    logic [PKT_W-1:0]    pkt_cnt;
    logic [PKT_W-1:0]    pkt_after;
    logic                flush_pend;
    logic                flush_after;
    logic                flush_set;
    logic                err_pend;
    logic                tvalid_q;
    logic                tlast_q;
    logic                accept;
    logic                hs;
    logic                rec_done;
    logic                close_rec;
    logic                drop;
    logic                fifo_wr;
    logic                fifo_rd;
    logic                fifo_full;
    logic                fifo_empty;
    logic [PC_WIDTH-1:0] fifo_rd_data;

    assign M_AXIS.tvalid = tvalid_q;
    assign M_AXIS.tlast  = tlast_q;
    assign M_AXIS.tdata  = shreg[TDATA_WIDTH-1:0];

    pc_trace_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (i_pc),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // pkt_after/flush_after are the packet state as seen by the next record,
    // so tlast can be registered one beat ahead and stays stable under stall.
    always_comb begin
        accept      = i_pc_valid && !err_pend && (state != HALT);
        hs          = tvalid_q && M_AXIS.tready;
        rec_done    = (state == BEAT) && hs && (beat_cnt == LAST_BEAT);
        fifo_rd     = ((state == IDLE) && !fifo_empty) ||
                      (rec_done && !fifo_empty && !err_pend);
        fifo_wr     = accept && (!fifo_full || fifo_rd);
        drop        = accept && fifo_full && !fifo_rd;
        flush_set   = i_flush && ((state == BEAT) || !fifo_empty);
        next_beat   = beat_cnt + 1'b1;
        pkt_after   = pkt_cnt;
        flush_after = flush_pend;
        if (rec_done) begin
            if (tlast_q) begin
                pkt_after   = '0;
                flush_after = 1'b0;
            end else begin
                pkt_after = pkt_cnt + 1'b1;
            end
        end
        flush_after = flush_after || flush_set;
        close_rec   = (pkt_after == LAST_REC) || flush_after;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            beat_cnt     <= '0;
            pkt_cnt      <= '0;
            flush_pend   <= 1'b0;
            err_pend     <= 1'b0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
            o_halted     <= 1'b0;
        end else begin
            pkt_cnt    <= pkt_after;
            flush_pend <= flush_after;
            if (i_error && (state != HALT)) err_pend <= 1'b1;

            if (i_clear) begin
                o_overflow   <= 1'b0;
                o_drop_count <= '0;
            end else if (drop) begin
                o_overflow <= 1'b1;
                if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg    <= fifo_rd_data;
                        beat_cnt <= '0;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (BEATS == 1) && close_rec;
                        state    <= BEAT;
                    end else if (err_pend) begin
                        shreg    <= ERR_WORD;
                        beat_cnt <= '0;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (BEATS == 1);
                        state    <= ERR_BEAT;
                    end
                end
                BEAT: begin
                    if (hs) begin
                        if (beat_cnt == LAST_BEAT) begin
                            if (!fifo_empty && !err_pend) begin
                                shreg    <= fifo_rd_data;
                                beat_cnt <= '0;
                                tlast_q  <= (BEATS == 1) && close_rec;
                            end else begin
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            shreg    <= shreg >> TDATA_WIDTH;
                            beat_cnt <= next_beat;
                            tlast_q  <= (next_beat == LAST_BEAT) && close_rec;
                        end
                    end
                end
                ERR_BEAT: begin
                    if (hs) begin
                        if (beat_cnt == LAST_BEAT) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            o_halted <= 1'b1;
                            state    <= HALT;
                        end else begin
                            shreg    <= shreg >> TDATA_WIDTH;
                            beat_cnt <= next_beat;
                            tlast_q  <= (next_beat == LAST_BEAT);
                        end
                    end
                end
                HALT: begin
                    if (i_clear) begin
                        o_halted   <= 1'b0;
                        err_pend   <= 1'b0;
                        pkt_cnt    <= '0;
                        flush_pend <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_trace_stream.sv
// Directed bench for pc_trace_stream: a cycle table for single-sample and
// error/halt behaviour, plus sequences for framing, backpressure, overflow, flush, reset.
module tb_pc_trace_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_pc;
    logic        i_pc_valid;
    logic        i_error;
    logic        i_flush;
    logic        i_clear;
    logic        o_overflow;
    logic [15:0] o_drop_count;
    logic        o_halted;

    int checks = 0;
    int passed = 0;

    pc_trace_stream_if #(.TDATA_WIDTH(16)) axis ();

    pc_trace_stream #(
        .PC_WIDTH    (32),
        .TDATA_WIDTH (16),
        .FIFO_DEPTH  (32),
        .PKT_LEN     (16),
        .ERR_WORD    (32'h0000_0001)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pc         (i_pc),
        .i_pc_valid   (i_pc_valid),
        .i_error      (i_error),
        .i_flush      (i_flush),
        .i_clear      (i_clear),
        .M_AXIS       (axis.master),
        .o_overflow   (o_overflow),
        .o_drop_count (o_drop_count),
        .o_halted     (o_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        err;
        logic        clr;
        logic        e_tvalid;
        logic [15:0] e_tdata;
        logic        e_tlast;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, input logic [31:0] pc, input logic err,
                                input logic clr, input logic e_tv, input logic [15:0] e_td,
                                input logic e_tl, input logic e_h);
        vec_t v;
        v.vld = vld; v.pc = pc; v.err = err; v.clr = clr;
        v.e_tvalid = e_tv; v.e_tdata = e_td; v.e_tlast = e_tl; v.e_halted = e_h;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic idleInputs();
        i_pc_valid = 1'b0;
        i_pc       = '0;
        i_error    = 1'b0;
        i_flush    = 1'b0;
        i_clear    = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        i_pc_valid  = v.vld;
        i_pc        = v.pc;
        i_error     = v.err;
        i_clear     = v.clr;
        i_flush     = 1'b0;
        axis.tready = 1'b1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        axis.tready = 1'b0;
        #1;
        checkOutput("reset tvalid", axis.tvalid, 0);
        checkOutput("reset tlast", axis.tlast, 0);
        checkOutput("reset tdata", axis.tdata, 0);
        checkOutput("reset overflow", o_overflow, 0);
        checkOutput("reset drop_count", o_drop_count, 0);
        checkOutput("reset halted", o_halted, 0);
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic writePc(input logic [31:0] pc);
        i_pc_valid = 1'b1;
        i_pc       = pc;
        tick();
        i_pc_valid = 1'b0;
    endtask

    // Expects tready high; waits a bounded time for tvalid, checks the beat, then consumes it.
    task automatic takeBeat(input string name, input logic [15:0] exp_data, input logic exp_last,
                            output int waited);
        waited = 0;
        while (axis.tvalid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput({name, " tvalid"}, axis.tvalid, 1);
        checkOutput({name, " tdata"}, axis.tdata, exp_data);
        checkOutput({name, " tlast"}, axis.tlast, exp_last);
        tick();
    endtask

    task automatic takeRecord(input int r, input logic [31:0] pc, input logic exp_last);
        int w;
        takeBeat($sformatf("rec%0d lo", r), pc[15:0], 1'b0, w);
        takeBeat($sformatf("rec%0d hi", r), pc[31:16], exp_last, w);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          w;
        logic [31:0] pc;
        logic [31:0] pc_a, pc_b, pc_c, pc_d, pc_x, pc_y;

        // ---------------- cycle table: single sample, error ordering, halt, clear
        doReset();
        pc_a = 32'h1000_0010; pc_b = 32'h2000_0020; pc_c = 32'h3000_0030;
        pc_d = 32'h4000_0040; pc_x = 32'hDEAD_BEEF; pc_y = 32'h5000_0050;
        vecs.push_back(mk(1, 32'h8000_0004, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h8000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, pc_a, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, pc_b, 0, 0, 1, 16'h0010, 0, 0));
        vecs.push_back(mk(1, pc_c, 0, 0, 1, 16'h1000, 0, 0));
        vecs.push_back(mk(1, pc_d, 1, 0, 1, 16'h0020, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h2000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0030, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h3000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0040, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h4000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0001, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(1, pc_x, 0, 0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, pc_y, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0050, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h5000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d tvalid", i), axis.tvalid, vecs[i].e_tvalid);
            if (vecs[i].e_tvalid) begin
                checkOutput($sformatf("vec%0d tdata", i), axis.tdata, vecs[i].e_tdata);
                checkOutput($sformatf("vec%0d tlast", i), axis.tlast, vecs[i].e_tlast);
            end
            checkOutput($sformatf("vec%0d halted", i), o_halted, vecs[i].e_halted);
            checkOutput($sformatf("vec%0d drop_count", i), o_drop_count, 0);
        end
        idleInputs();

        // ---------------- packet framing: 16 PCs, 32 gapless beats, tlast on beat 32
        doReset();
        axis.tready = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    i_pc_valid = 1'b1;
                    i_pc       = 32'h100 + 32'(4 * i);
                    tick();
                end
                i_pc_valid = 1'b0;
            end
            begin
                for (int r = 0; r < 16; r++) begin
                    for (int b = 0; b < 2; b++) begin
                        pc = 32'h100 + 32'(4 * r);
                        takeBeat($sformatf("frame rec%0d b%0d", r, b),
                                 (b == 0) ? pc[15:0] : pc[31:16], (r == 15 && b == 1), w);
                        if (r == 0 && b == 0) checkOutput("frame first latency", 32'(w), 2);
                        else checkOutput($sformatf("frame gap rec%0d b%0d", r, b), 32'(w), 0);
                    end
                end
            end
        join
        checkOutput("frame idle after", axis.tvalid, 0);

        // ---------------- backpressure: 10-cycle stall mid-record
        doReset();
        writePc(32'hCAFE_1234);
        writePc(32'hBEEF_5678);
        repeat (2) tick();
        checkOutput("bp first tvalid", axis.tvalid, 1);
        checkOutput("bp first tdata", axis.tdata, 32'h1234);
        axis.tready = 1'b1;
        tick();
        axis.tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("bp stall%0d tvalid", i), axis.tvalid, 1);
            checkOutput($sformatf("bp stall%0d tdata", i), axis.tdata, 32'hCAFE);
            checkOutput($sformatf("bp stall%0d tlast", i), axis.tlast, 0);
        end
        axis.tready = 1'b1;
        takeBeat("bp held hi", 16'hCAFE, 1'b0, w);
        checkOutput("bp held no wait", 32'(w), 0);
        takeRecord(1, 32'hBEEF_5678, 1'b0);
        checkOutput("bp idle after", axis.tvalid, 0);

        // ---------------- overflow: one record in flight, then 40 writes against a stalled sink
        doReset();
        writePc(32'hF000_0000);
        repeat (3) tick();
        for (int i = 0; i < 40; i++) begin
            i_pc_valid = 1'b1;
            i_pc       = 32'h1000_0000 + 32'(i);
            tick();
        end
        i_pc_valid = 1'b0;
        tick();
        checkOutput("ovf overflow", o_overflow, 1);
        checkOutput("ovf drop_count", o_drop_count, 8);
        checkOutput("ovf held tdata", axis.tdata, 32'h0000);
        axis.tready = 1'b1;
        takeRecord(0, 32'hF000_0000, 1'b0);
        for (int i = 0; i < 32; i++) begin
            takeRecord(i + 1, 32'h1000_0000 + 32'(i), ((i + 1) % 16) == 15);
        end
        repeat (2) tick();
        checkOutput("ovf drained", axis.tvalid, 0);
        checkOutput("ovf sticky", o_overflow, 1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        checkOutput("ovf clear overflow", o_overflow, 0);
        checkOutput("ovf clear drop_count", o_drop_count, 0);

        // ---------------- flush during record 5 restarts the packet
        doReset();
        for (int i = 0; i < 21; i++) begin
            i_pc_valid = 1'b1;
            i_pc       = 32'h2000_0000 + 32'(i) * 32'h0001_0001;
            tick();
        end
        i_pc_valid = 1'b0;
        tick();
        axis.tready = 1'b1;
        for (int r = 0; r < 4; r++) takeRecord(r, 32'h2000_0000 + 32'(r) * 32'h0001_0001, 1'b0);
        i_flush = 1'b1;
        takeBeat("flush rec4 lo", 16'h0004, 1'b0, w);
        i_flush = 1'b0;
        takeBeat("flush rec4 hi", 16'h2004, 1'b1, w);
        for (int r = 5; r < 21; r++) takeRecord(r, 32'h2000_0000 + 32'(r) * 32'h0001_0001, r == 20);
        checkOutput("flush idle after", axis.tvalid, 0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        writePc(32'h6000_0060);
        takeRecord(99, 32'h6000_0060, 1'b0);

        // ---------------- asynchronous reset mid-beat
        doReset();
        writePc(32'h7777_8888);
        repeat (2) tick();
        checkOutput("rst pre tvalid", axis.tvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst async tvalid", axis.tvalid, 0);
        checkOutput("rst async tdata", axis.tdata, 0);
        checkOutput("rst async tlast", axis.tlast, 0);
        checkOutput("rst async drop_count", o_drop_count, 0);
        tick();
        rst = 1'b0;
        axis.tready = 1'b1;
        repeat (3) tick();
        checkOutput("rst record lost", axis.tvalid, 0);
        writePc(32'h9999_AAAA);
        takeRecord(100, 32'h9999_AAAA, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
